aes_s2mm_sts: RTL

//  Reader side of the AES S2MM end-of-frame FIFO. Snoops the AES S2MM data stream to measure

---
 rtl/aes_s2mm_sts.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/aes_s2mm_sts.sv
// Measures each AES S2MM frame's byte length by snooping the data stream, then pairs it with an
// EOF-FIFO entry and emits the 5-word DMA S2MM status packet carrying the true length.
module aes_s2mm_sts #(
    parameter C_FAMILY                      = "virtex6",
    parameter int C_S_AXIS_S2MM_TDATA_WIDTH     = 128,
    parameter int C_S_AXIS_S2MM_STS_TDATA_WIDTH = 32,
    parameter int C_LEN_WIDTH                   = 23,
    parameter int C_LEN_DEPTH                   = 4
) (
    input  logic                                       m_axi_s2mm_aclk,
    input  logic                                       s2mm_prmry_reset,
    input  logic                                       s_axis_s2mm_tvalid,
    input  logic                                       s_axis_s2mm_tready,
    input  logic                                       s_axis_s2mm_tlast,
    input  logic [C_S_AXIS_S2MM_TDATA_WIDTH/8-1:0]     s_axis_s2mm_tkeep,
    input  logic                                       aes_s2mm_eof_empty,
    output logic                                       aes_s2mm_eof_rd,
    output logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH-1:0]   s_axis_s2mm_sts_tdata,
    output logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH/8-1:0] s_axis_s2mm_sts_tkeep,
    output logic                                       s_axis_s2mm_sts_tvalid,
    output logic                                       s_axis_s2mm_sts_tlast,
    input  logic                                       s_axis_s2mm_sts_tready,
    output logic                                       sts_len_full,
    output logic [15:0]                                sts_frame_cnt
);

    // state | meaning
    // IDLE  | waiting for both a queued length and a non-empty EOF FIFO
    // POP   | one-cycle EOF pop, head length captured
    // SEND  | streaming status words 0..4
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    localparam int KW = C_S_AXIS_S2MM_TDATA_WIDTH / 8;
    localparam int PW = $clog2(KW + 1);
    localparam int AW = $clog2(C_LEN_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [C_LEN_WIDTH-1:0] LEN_MAX = '1;

    logic [1:0]             state;
    logic [2:0]             w_idx;
    logic [C_LEN_WIDTH-1:0] acc;
    logic [C_LEN_WIDTH-1:0] len_r;
    logic [C_LEN_WIDTH-1:0] len_q [C_LEN_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          q_cnt;
    logic [CW-1:0]          q_cnt_nxt;
    logic                   ovf;
    logic [31:0]            tdata_r;

    logic [PW-1:0]          keep_cnt;
    logic [C_LEN_WIDTH:0]   acc_sum;
    logic [C_LEN_WIDTH-1:0] acc_sat;
    logic                   beat;
    logic                   push_req;
    logic                   pop;
    logic                   q_full;
    logic                   push;

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < KW; i++) begin
            keep_cnt = keep_cnt + {{(PW-1){1'b0}}, s_axis_s2mm_tkeep[i]};
        end
    end

    assign acc_sum  = {1'b0, acc} + {{(C_LEN_WIDTH+1-PW){1'b0}}, keep_cnt};
    assign acc_sat  = acc_sum[C_LEN_WIDTH] ? LEN_MAX : acc_sum[C_LEN_WIDTH-1:0];
    assign beat     = s_axis_s2mm_tvalid & s_axis_s2mm_tready;
    assign push_req = beat & s_axis_s2mm_tlast;
    assign pop      = (state == ST_POP);
    assign q_full   = (q_cnt == CW'(C_LEN_DEPTH));
    // A pop on the same edge frees the slot the push needs, so a full queue only drops without one.
    assign push     = push_req & (~q_full | pop);

    always_comb begin
        q_cnt_nxt = q_cnt;
        if (push && !pop) begin
            q_cnt_nxt = q_cnt + CW'(1);
        end else if (pop && !push) begin
            q_cnt_nxt = q_cnt - CW'(1);
        end
    end

    always_ff @(posedge m_axi_s2mm_aclk) begin
        if (push) begin
            len_q[wr_ptr] <= acc_sat;
        end
    end

    always_ff @(posedge m_axi_s2mm_aclk or posedge s2mm_prmry_reset) begin
        if (s2mm_prmry_reset) begin
            acc          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            q_cnt        <= '0;
            sts_len_full <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            if (beat) begin
                acc <= s_axis_s2mm_tlast ? '0 : acc_sat;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_req && !push) begin
                ovf <= 1'b1;
            end
            q_cnt        <= q_cnt_nxt;
            sts_len_full <= (q_cnt_nxt == CW'(C_LEN_DEPTH));
        end
    end

    // Words are registered so the DMA sees stable data across stalls even if ovf changes meanwhile.
    always_ff @(posedge m_axi_s2mm_aclk or posedge s2mm_prmry_reset) begin
        if (s2mm_prmry_reset) begin
            state         <= ST_IDLE;
            w_idx         <= '0;
            len_r         <= '0;
            tdata_r       <= '0;
            sts_frame_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!aes_s2mm_eof_empty && q_cnt != '0) begin
                        state <= ST_POP;
                    end
                end
                ST_POP: begin
                    len_r   <= len_q[rd_ptr];
                    tdata_r <= {4'h5, 11'h0, ovf, sts_frame_cnt};
                    w_idx   <= '0;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (s_axis_s2mm_sts_tready) begin
                        if (w_idx == 3'd4) begin
                            state         <= ST_IDLE;
                            sts_frame_cnt <= sts_frame_cnt + 16'd1;
                        end else begin
                            w_idx   <= w_idx + 3'd1;
                            tdata_r <= (w_idx == 3'd3) ? {{(32-C_LEN_WIDTH){1'b0}}, len_r} : 32'h0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign aes_s2mm_eof_rd        = (state == ST_POP);
    assign s_axis_s2mm_sts_tvalid = (state == ST_SEND);
    assign s_axis_s2mm_sts_tlast  = (state == ST_SEND) && (w_idx == 3'd4);
    assign s_axis_s2mm_sts_tdata  = tdata_r;
    assign s_axis_s2mm_sts_tkeep  = '1;

endmodule
